fib_table_reader: RTL and testbench



---
 rtl/fib_table_reader_if.sv | 13 +
 rtl/fib_table_reader.sv | 140 ++++++++++++++
 tb/tb_fib_table_reader.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/fib_table_reader_if.sv
// Valid/ready stream carrying one RAM word and the address it was read from.
interface fib_table_reader_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5
);
   logic [DATA_W-1:0] out_data;
   logic [ADDR_W-1:0] out_index;
   logic              out_valid;
   logic              out_ready;

   modport master (output out_data, output out_index, output out_valid, input out_ready);
   modport slave  (input out_data, input out_index, input out_valid, output out_ready);
endinterface

// File: rtl/fib_table_reader.sv
// Scans RAM port B 0..DEPTH-1 after start and streams the words through a 2-entry skid buffer.
// Optional Fibonacci recurrence checker enabled by defining FIB_CHECK_EN.
module fib_table_reader #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DEPTH  = 30
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   output logic [ADDR_W-1:0]    ram_addrb,
   input  logic [DATA_W-1:0]    ram_doutb,
   fib_table_reader_if.master   strm,
   output logic                 busy,
   output logic                 done,
   output logic                 err
);
   localparam int unsigned CNT_W = ADDR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(DEPTH - 1);

   typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  issue_addr;
   logic              inflight;
   logic [ADDR_W-1:0] inflight_idx;
   logic [1:0]        occ, occ_nxt, occ_after_pop;
   logic [DATA_W-1:0] ent1_data;
   logic [ADDR_W-1:0] ent1_idx;
   logic              pop, issue, scan_start, credit_ok;

   // The issue address register is presented to the RAM directly; a read counts only when issued.
   assign ram_addrb     = issue_addr[ADDR_W-1:0];
   assign pop           = strm.out_valid && strm.out_ready;
   assign occ_after_pop = occ - {1'b0, pop};
   assign occ_nxt       = occ_after_pop + {1'b0, inflight};
   assign credit_ok     = ({1'b0, occ} + {2'b0, inflight}) < (3'd2 + {2'b0, pop});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      issue      = 1'b0;
      scan_start = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               scan_start = 1'b1;
               issue      = 1'b1;
               state_nxt  = READ;
            end
         end
         READ: begin
            if (issue_addr < DEPTH_C && credit_ok) begin
               issue = 1'b1;
               if (issue_addr == LAST_C) state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (occ == 2'd0 && !inflight) state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Issue counter, in-flight tracking and skid buffer (head lives in the stream outputs).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         issue_addr     <= '0;
         inflight       <= 1'b0;
         inflight_idx   <= '0;
         occ            <= 2'd0;
         ent1_data      <= '0;
         ent1_idx       <= '0;
         strm.out_data  <= '0;
         strm.out_index <= '0;
         strm.out_valid <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
      end else begin
         if (scan_start)         issue_addr <= CNT_W'(1);
         else if (issue)         issue_addr <= issue_addr + CNT_W'(1);
         else if (state == DONE) issue_addr <= '0;

         inflight <= issue;
         if (issue) inflight_idx <= issue_addr[ADDR_W-1:0];

         if (pop) begin
            strm.out_data  <= ent1_data;
            strm.out_index <= ent1_idx;
         end
         if (inflight) begin
            if (occ_after_pop == 2'd0) begin
               strm.out_data  <= ram_doutb;
               strm.out_index <= inflight_idx;
            end else begin
               ent1_data <= ram_doutb;
               ent1_idx  <= inflight_idx;
            end
         end
         occ            <= occ_nxt;
         strm.out_valid <= (occ_nxt != 2'd0);
         busy           <= (state_nxt != IDLE);
         done           <= (state_nxt == DONE);
      end
   end

   assert property (@(posedge clk) disable iff (!rst_n) !(occ == 2'd2 && inflight && !pop))
      else $error("skid buffer overflow");

`ifdef FIB_CHECK_EN
   logic [DATA_W-1:0] p1, p2, fib_sum;

   assign fib_sum = p1 + p2;

   // Recurrence check on every accepted word from index 2 onward; sticky until the next scan.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p1  <= '0;
         p2  <= '0;
         err <= 1'b0;
      end else begin
         if (scan_start) err <= 1'b0;
         else if (pop && strm.out_index >= ADDR_W'(2) && strm.out_data != fib_sum) err <= 1'b1;
         if (pop) begin
            p2 <= p1;
            p1 <= strm.out_data;
         end
      end
   end
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_fib_table_reader.sv
// Randomized-backpressure bench for fib_table_reader against a stream-level reference model.
module tb_fib_table_reader;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 5;
   localparam int unsigned DEPTH  = 30;
`ifdef FIB_CHECK_EN
   localparam bit CHK_EN = 1'b1;
`else
   localparam bit CHK_EN = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic [ADDR_W-1:0] ram_addrb;
   logic [DATA_W-1:0] ram_doutb;
   logic              busy, done, err;

   fib_table_reader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) strm ();

   fib_table_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .ram_addrb (ram_addrb),
      .ram_doutb (ram_doutb),
      .strm      (strm),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   logic [DATA_W-1:0] mem     [2**ADDR_W];
   logic [DATA_W-1:0] ref_mem [2**ADDR_W];

   always @(posedge clk) ram_doutb <= mem[ram_addrb];

   int unsigned checks = 0;
   int unsigned failures = 0;
   int          cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference-model state for the scan under way.
   bit                mon_en = 1'b0;
   int                mode, start_cyc, exp_idx, first_valid_k, last_acc_k, done_k, done_cnt;
   bit                prev_stall, exp_err;
   logic [DATA_W-1:0] prev_data;
   logic [ADDR_W-1:0] prev_idx;

   always @(negedge clk) begin
      int k;
      int ahead;
      if (mon_en) begin
         k = cyc - start_cyc;
         if (k > 0) check("err", err, CHK_EN ? exp_err : 1'b0);
         if (prev_stall) begin
            check("hold_valid", strm.out_valid, 1);
            check("hold_data", strm.out_data, prev_data);
            check("hold_index", strm.out_index, prev_idx);
         end
         if (busy) begin
            ahead = int'(ram_addrb) - exp_idx;
            check("addr_ahead_le2", ahead <= 2, 1);
         end
         if (mode == 2 && k >= 3 && k < 20) begin
            check("stall_valid", strm.out_valid, 1);
            check("stall_index", strm.out_index, 0);
            check("stall_fetched", ram_addrb, 2);
         end
         if (strm.out_valid && first_valid_k < 0) first_valid_k = k;
         if (done) begin
            done_cnt++;
            done_k = k;
         end
         if (strm.out_valid && strm.out_ready) begin
            if (exp_idx < int'(DEPTH)) begin
               check("index", strm.out_index, exp_idx);
               check("data", strm.out_data, ref_mem[exp_idx]);
               if (exp_idx >= 2 && ref_mem[exp_idx] != DATA_W'(ref_mem[exp_idx-1] + ref_mem[exp_idx-2]))
                  exp_err = 1'b1;
            end else begin
               check("extra_word", exp_idx, DEPTH - 1);
            end
            last_acc_k = k;
            exp_idx++;
         end
         prev_stall = strm.out_valid && !strm.out_ready;
         prev_data  = strm.out_data;
         prev_idx   = strm.out_index;
      end
   end

   function automatic logic ready_for(input int m, input int k);
      case (m)
         1:       return (k % 4 == 0) || (k % 4 == 3);
         2:       return k >= 20;
         3:       return ($urandom_range(0, 3) != 0);
         default: return 1'b1;
      endcase
   endfunction

   task automatic check_reset_values(input string tag);
      check({tag, "_addrb"}, ram_addrb, 0);
      check({tag, "_data"}, strm.out_data, 0);
      check({tag, "_index"}, strm.out_index, 0);
      check({tag, "_valid"}, strm.out_valid, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_err"}, err, 0);
   endtask

   // Modes: 0 ready high, 1 pattern 1001, 2 stall 20, 3 random, 4 reset at index 12, 5 restart at 5.
   task automatic run_scan(input int m);
      bit fired;
      mode          = m;
      exp_idx       = 0;
      first_valid_k = -1;
      last_acc_k    = -1;
      done_k        = -1;
      done_cnt      = 0;
      prev_stall    = 1'b0;
      exp_err       = 1'b0;
      fired         = 1'b0;
      @(posedge clk);
      #1;
      start          = 1'b1;
      start_cyc      = cyc;
      strm.out_ready = ready_for(m, 0);
      mon_en         = 1'b1;
      check("busy_before_start", busy, 0);
      for (int k = 1; k < 400; k++) begin
         @(posedge clk);
         #1;
         start          = 1'b0;
         strm.out_ready = ready_for(m, k);
         if (k == 1) check("busy_after_start", busy, 1);
         if (m == 5 && exp_idx == 5 && !fired) begin
            start = 1'b1;
            fired = 1'b1;
         end
         if (m == 4 && exp_idx == 12) begin
            mon_en = 1'b0;
            rst_n  = 1'b0;
            #1;
            check_reset_values("midscan_rst");
            @(posedge clk);
            #1;
            rst_n = 1'b1;
            for (int j = 0; j < 40; j++) begin
               @(posedge clk);
               #1;
               check("no_done_after_rst", done, 0);
            end
            check("done_count_rst", done_cnt, 0);
            check_reset_values("after_rst");
            return;
         end
         if (done_cnt > 0 && k >= done_k + 3) break;
      end
      mon_en = 1'b0;
      check("done_count", done_cnt, 1);
      check("words_delivered", exp_idx, DEPTH);
      check("first_valid_latency", first_valid_k, 2);
      check("idle_after_done", busy, 0);
      check("valid_after_done", strm.out_valid, 0);
      check("err_final", err, CHK_EN ? exp_err : 1'b0);
      if (m == 0 || m == 5) begin
         check("last_accept_cycle", last_acc_k, DEPTH + 1);
         check("done_cycle", done_k, DEPTH + 3);
      end
   endtask

   initial begin
      ref_mem[0] = '0;
      ref_mem[1] = DATA_W'(1);
      for (int i = 2; i < 2**ADDR_W; i++) ref_mem[i] = ref_mem[i-1] + ref_mem[i-2];
      for (int i = int'(DEPTH); i < 2**ADDR_W; i++) ref_mem[i] = DATA_W'($urandom);
      for (int i = 0; i < 2**ADDR_W; i++) mem[i] = ref_mem[i];
      check("fib29_ref", ref_mem[29], 514229);

      strm.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_values("reset");
      rst_n = 1'b1;

      run_scan(0);
      run_scan(1);
      run_scan(2);
      repeat (3) run_scan(3);
      run_scan(5);

      mem[10]     = DATA_W'(56);
      ref_mem[10] = DATA_W'(56);
      run_scan(0);
      mem[10]     = DATA_W'(55);
      ref_mem[10] = DATA_W'(55);
      run_scan(0);

      run_scan(4);
      run_scan(0);
      run_scan(3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
